// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Purpose  : Shared widths, scheduler state encoding and the chunk-write request record.
// Revision : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    localparam int          CHUNK_W      = 32;
    localparam int          ROW_W        = 4;
    localparam int          CHUNK_ADDR_W = 4;
    localparam int          PANEL_W      = 2;
    localparam logic [3:0]  LAST_CHUNK   = 4'd15;

    typedef enum logic [0:0] {
        RR     = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [PANEL_W-1:0]      panel;
        logic [ROW_W-1:0]        row;
        logic [CHUNK_ADDR_W-1:0] chunk;
        logic [CHUNK_W-1:0]      data;
    } chunk_req_t;

    // The row being scanned out, and optionally the one after it, must not be rewritten.
    function automatic logic row_conflict(input logic [ROW_W-1:0] row,
                                          input logic [ROW_W-1:0] active,
                                          input logic             guard_next);
        logic [ROW_W-1:0] next_row;
        next_row = active + 4'd1;
        return (row == active) | (guard_next & (row == next_row));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_2
// Purpose  : Two-way round-robin grant with a host override; pointer favours host out of reset.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic clk,
    input  logic reset,
    input  logic elig_host,
    input  logic elig_pat,
    input  logic xfer,
    input  logic force_host,
    output logic grant_host,
    output logic grant_pat
);

    // Records which side was served last; the other side wins a tie.
    logic r_last_host;

    always_comb begin
        grant_host = elig_host & (force_host | ~elig_pat | ~r_last_host);
        grant_pat  = elig_pat & ~force_host & (~elig_host | r_last_host);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_host <= 1'b0;
        end else if (xfer) begin
            r_last_host <= grant_host;
        end
    end

endmodule
`default_nettype wire

// File: rtl/chunk_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : chunk_write_scheduler
// Purpose  : Arbitrates host and pattern chunk writes onto the LED controller write port,
//            with host row-lock and tear guard. Optional stall counter: CHUNK_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_write_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int GUARD_NEXT = 1,
    parameter int STAT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_valid,
    output logic                    host_ready,
    input  logic                    host_lock,
    input  logic [PANEL_W-1:0]      host_panel,
    input  logic [ROW_W-1:0]        host_row,
    input  logic [CHUNK_ADDR_W-1:0] host_chunk,
    input  logic [CHUNK_W-1:0]      host_data,
    input  logic                    pat_valid,
    output logic                    pat_ready,
    input  logic [PANEL_W-1:0]      pat_panel,
    input  logic [ROW_W-1:0]        pat_row,
    input  logic [CHUNK_ADDR_W-1:0] pat_chunk,
    input  logic [CHUNK_W-1:0]      pat_data,
    input  logic [ROW_W-1:0]        active_row_addr,
    output logic                    chunk_write_enable,
    output logic [CHUNK_W-1:0]      chunk_data,
    output logic [CHUNK_ADDR_W-1:0] chunk_addr,
    output logic [ROW_W-1:0]        row_addr,
    output logic [PANEL_W-1:0]      panel_addr,
    output logic                    locked,
    output logic [STAT_W-1:0]       stall_cycles
);

    localparam logic c_guard_next = (GUARD_NEXT != 0);

    sched_state_e r_state;
    sched_state_e w_state_next;
    chunk_req_t   w_host_req;
    chunk_req_t   w_pat_req;
    chunk_req_t   r_out;
    logic         r_we;
    logic         w_conflict_host;
    logic         w_conflict_pat;
    logic         w_elig_host;
    logic         w_elig_pat;
    logic         w_grant_host;
    logic         w_grant_pat;
    logic         w_xfer;
    logic         w_force_host;

    assign w_host_req = '{panel: host_panel, row: host_row, chunk: host_chunk, data: host_data};
    assign w_pat_req  = '{panel: pat_panel,  row: pat_row,  chunk: pat_chunk,  data: pat_data};

    assign w_conflict_host = row_conflict(host_row, active_row_addr, c_guard_next);
    assign w_conflict_pat  = row_conflict(pat_row,  active_row_addr, c_guard_next);
    assign w_elig_host     = host_valid & ~w_conflict_host;
    assign w_elig_pat      = pat_valid  & ~w_conflict_pat;
    assign w_force_host    = (r_state == LOCKED);

    rr_arbiter_2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .elig_host  (w_elig_host),
        .elig_pat   (w_elig_pat),
        .xfer       (w_xfer),
        .force_host (w_force_host),
        .grant_host (w_grant_host),
        .grant_pat  (w_grant_pat)
    );

    // A grant only goes to an eligible (hence valid) side, so grant equals transfer.
    assign host_ready = w_grant_host;
    assign pat_ready  = w_grant_pat;
    assign w_xfer     = w_grant_host | w_grant_pat;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RR: begin
                if (w_grant_host && host_lock && (host_chunk == '0)) begin
                    w_state_next = LOCKED;
                end
            end
            LOCKED: begin
                if ((w_grant_host && (host_chunk == LAST_CHUNK)) || !host_lock) begin
                    w_state_next = RR;
                end
            end
            default: w_state_next = RR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RR;
            r_we    <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_we    <= w_xfer;
            if (w_grant_host) begin
                r_out <= w_host_req;
            end else if (w_grant_pat) begin
                r_out <= w_pat_req;
            end
        end
    end

    assign chunk_write_enable = r_we;
    assign chunk_data         = r_out.data;
    assign chunk_addr         = r_out.chunk;
    assign row_addr           = r_out.row;
    assign panel_addr         = r_out.panel;
    assign locked             = (r_state == LOCKED);

`ifdef CHUNK_SCHED_STATS_EN
    logic [STAT_W-1:0] r_stall;
    logic              w_stall_evt;

    assign w_stall_evt = ((host_valid & w_conflict_host) | (pat_valid & w_conflict_pat)) & ~w_xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (w_stall_evt && (r_stall != '1)) begin
            r_stall <= r_stall + STAT_W'(1);
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire
